// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its scoreboard comparator.
package pipe_hazard_ctrl_pkg;

    // Scoreboard rd storage width; REG_AW of the controller must not exceed this.
    localparam int SB_RD_W = 8;

    // fwd_sel encoding: 0 selects the register file, k selects scoreboard entry k-1.
    localparam int FWD_RF = 0;

    localparam logic [SB_RD_W-1:0] R0_ADDR = 8'd0;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               we;
        logic               load;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: 8'd0, we: 1'b0, load: 1'b0};

endpackage

// File: rtl/pipe_sb_match.sv
// Per-source scoreboard comparator: match vector over all entries, in-flight load flags,
// and the forwarding select of the youngest matching entry ahead of WB.
module pipe_sb_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic [SB_RD_W-1:0]    src_addr,
    input  logic                  src_re,
    input  sb_entry_t [DEPTH-1:0] entries,
    output logic [DEPTH-1:0]      match_vec,
    output logic [DEPTH-1:0]      load_vec,
    output logic [SEL_W-1:0]      young_sel
);

    // Compare every entry, then walk from oldest to youngest so the lowest index wins
    always_comb begin
        match_vec = {DEPTH{1'b0}};
        load_vec  = {DEPTH{1'b0}};
        young_sel = SEL_W'(FWD_RF);
        for (int k = 0; k < DEPTH; k++) begin
            match_vec[k] = src_re && (src_addr != R0_ADDR) && entries[k].valid
                           && entries[k].we && (entries[k].rd == src_addr);
            load_vec[k]  = entries[k].valid && entries[k].load;
        end
        // WB (entry DEPTH-1) is visible through the register file, so it is never selected
        for (int k = DEPTH - 2; k >= 0; k--) begin
            young_sel = match_vec[k] ? SEL_W'(k + 1) : young_sel;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW scoreboard, hold/bubble/flush and stall counter.
// Define PIPE_FWD_EN to drive the forwarding selects; only load-use dependences then stall.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int  DEPTH  = 3,
    parameter int  REG_AW = 4,
    parameter int  CNT_W  = 16,
    localparam int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic              id_rs_re,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic              id_rt_re,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              ex_branch_taken,
    output logic              hold,
    output logic              bubble,
    output logic              flush,
    output logic [SEL_W-1:0]  fwd_sel_a,
    output logic [SEL_W-1:0]  fwd_sel_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Only the EX entry can be a load-use producer.
    localparam logic [DEPTH-1:0] LU_MASK = {{(DEPTH - 1){1'b0}}, 1'b1};

    sb_entry_t [DEPTH-1:0] sb_r;
    logic [CNT_W-1:0]      stall_cnt_r;
    sb_entry_t             id_entry_s;
    logic [DEPTH-1:0]      rs_match_s;
    logic [DEPTH-1:0]      rt_match_s;
    logic [DEPTH-1:0]      rs_load_s;
    logic [DEPTH-1:0]      rt_load_s;
    logic [SEL_W-1:0]      rs_sel_s;
    logic [SEL_W-1:0]      rt_sel_s;
    logic                  any_s;
    logic                  lu_s;
    logic                  raw_s;
    logic                  hold_s;
    logic                  flush_s;
    logic [SEL_W-1:0]      fwd_a_s;
    logic [SEL_W-1:0]      fwd_b_s;

    assign id_entry_s = '{valid: 1'b1, rd: SB_RD_W'(id_rd_addr), we: id_rd_we, load: id_is_load};

    pipe_sb_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_rs (
        .src_addr  (SB_RD_W'(id_rs_addr)),
        .src_re    (id_rs_re),
        .entries   (sb_r),
        .match_vec (rs_match_s),
        .load_vec  (rs_load_s),
        .young_sel (rs_sel_s)
    );

    pipe_sb_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_rt (
        .src_addr  (SB_RD_W'(id_rt_addr)),
        .src_re    (id_rt_re),
        .entries   (sb_r),
        .match_vec (rt_match_s),
        .load_vec  (rt_load_s),
        .young_sel (rt_sel_s)
    );

    // Zero-cycle hazard decision: flush beats stall, everything quiet during reset
    always_comb begin
        any_s   = (rs_sel_s != SEL_W'(FWD_RF)) || (rt_sel_s != SEL_W'(FWD_RF));
        lu_s    = |(((rs_match_s & rs_load_s) | (rt_match_s & rt_load_s)) & LU_MASK);
        raw_s   = 1'b0;
        flush_s = 1'b0;
        hold_s  = 1'b0;
        fwd_a_s = SEL_W'(FWD_RF);
        fwd_b_s = SEL_W'(FWD_RF);
        if (rst) begin
            raw_s   = 1'b0;
            flush_s = 1'b0;
            hold_s  = 1'b0;
        end else begin
`ifdef PIPE_FWD_EN
            raw_s   = id_valid && lu_s;
            fwd_a_s = any_s ? rs_sel_s : SEL_W'(FWD_RF);
            fwd_b_s = any_s ? rt_sel_s : SEL_W'(FWD_RF);
`else
            // a load-use hit is always also a non-WB hit; both are stalls here
            raw_s   = id_valid && (any_s || lu_s);
`endif
            flush_s = ex_branch_taken;
            hold_s  = raw_s && !flush_s;
        end
    end

    // Scoreboard shift towards WB and saturating count of hold cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_r[k] <= SB_EMPTY;
            end
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            sb_r[0] <= (id_valid && !hold_s && !flush_s) ? id_entry_s : SB_EMPTY;
            for (int k = 1; k < DEPTH; k++) begin
                sb_r[k] <= sb_r[k-1];
            end
            if (hold_s && !(&stall_cnt_r)) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign hold      = hold_s;
    assign bubble    = hold_s;
    assign flush     = flush_s;
    assign fwd_sel_a = fwd_a_s;
    assign fwd_sel_b = fwd_b_s;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (DEPTH=3, CNT_W=8); expectations cover
// both builds, selected by PIPE_FWD_EN.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [3:0] id_rs_addr = 4'd0;
    logic       id_rs_re = 1'b0;
    logic [3:0] id_rt_addr = 4'd0;
    logic       id_rt_re = 1'b0;
    logic [3:0] id_rd_addr = 4'd0;
    logic       id_rd_we = 1'b0;
    logic       id_is_load = 1'b0;
    logic       ex_branch_taken = 1'b0;
    logic       hold;
    logic       bubble;
    logic       flush;
    logic [1:0] fwd_sel_a;
    logic [1:0] fwd_sel_b;
    logic [7:0] stall_cnt;

    pipe_hazard_ctrl #(.DEPTH(3), .REG_AW(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rs_re(id_rs_re),
        .id_rt_addr(id_rt_addr), .id_rt_re(id_rt_re),
        .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken),
        .hold(hold), .bubble(bubble), .flush(flush),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic       h;
        logic       fl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   vid   = 0;

    // pick the hand-computed value for the active build
    function automatic logic [7:0] cn(input int n, input int f);
        return FWD ? 8'(f) : 8'(n);
    endfunction
    function automatic logic hn(input logic n, input logic f);
        return FWD ? f : n;
    endfunction
    function automatic logic [1:0] fs(input int f);
        return FWD ? 2'(f) : 2'd0;
    endfunction

    task automatic chk(input string nm, input int id, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL vec%0d %s got=%0d want=%0d", id, nm, got, want);
        end
    endtask

    // monitor: every cycle with a pending expectation is compared on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("hold",      e.id, {7'd0, hold},      {7'd0, e.h});
            chk("bubble",    e.id, {7'd0, bubble},    {7'd0, e.h});
            chk("flush",     e.id, {7'd0, flush},     {7'd0, e.fl});
            chk("fwd_sel_a", e.id, {6'd0, fwd_sel_a}, {6'd0, e.fa});
            chk("fwd_sel_b", e.id, {6'd0, fwd_sel_b}, {6'd0, e.fb});
            chk("stall_cnt", e.id, stall_cnt,         e.cnt);
        end
    end

    task automatic drv(input logic r, input logic v, input logic [3:0] rs, input logic rse,
                       input logic [3:0] rt, input logic rte, input logic [3:0] rd,
                       input logic we, input logic ld, input logic br);
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_rs_addr = rs; id_rs_re = rse;
        id_rt_addr = rt; id_rt_re = rte; id_rd_addr = rd; id_rd_we = we;
        id_is_load = ld; ex_branch_taken = br;
    endtask

    task automatic vec(input logic r, input logic v, input logic [3:0] rs, input logic rse,
                       input logic [3:0] rt, input logic rte, input logic [3:0] rd,
                       input logic we, input logic ld, input logic br,
                       input logic h, input logic fl, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [7:0] cnt);
        exp_t e;
        drv(r, v, rs, rse, rt, rte, rd, we, ld, br);
        vid++;
        e.id = vid; e.h = h; e.fl = fl; e.fa = fa; e.fb = fb; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic nops(input int n, input logic [7:0] cnt);
        for (int i = 0; i < n; i++) begin
            vec(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 2'd0, 2'd0, cnt);
        end
    endtask

    initial begin
        // reset with a branch and a would-be hazard on the inputs: everything stays quiet
        vec(1'b1, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);

        // back-to-back ALU dependence on rs: add r3 ; add r4,r3,r1
        vec(1'b0, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
        vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, hn(1'b1, 1'b0), 1'b0, fs(1), 2'd0, 8'd0);
        vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, hn(1'b1, 1'b0), 1'b0, fs(2), 2'd0, cn(1, 0));
        vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, cn(2, 0));
        nops(3, cn(2, 0));

        // same on rt: add r9 ; add r10,r1,r9
        vec(1'b0, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, cn(2, 0));
        vec(1'b0, 1'b1, 4'd1, 1'b1, 4'd9, 1'b1, 4'd10, 1'b1, 1'b0, 1'b0, hn(1'b1, 1'b0), 1'b0, 2'd0, fs(1), cn(2, 0));
        vec(1'b0, 1'b1, 4'd1, 1'b1, 4'd9, 1'b1, 4'd10, 1'b1, 1'b0, 1'b0, hn(1'b1, 1'b0), 1'b0, 2'd0, fs(2), cn(3, 0));
        vec(1'b0, 1'b1, 4'd1, 1'b1, 4'd9, 1'b1, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, cn(4, 0));
        nops(3, cn(4, 0));

        // load r5 ; add r6,r5,r2 : one load-use cycle with forwarding, then MEM forward
        vec(1'b0, 1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, cn(4, 0));
        vec(1'b0, 1'b1, 4'd5, 1'b1, 4'd2, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, fs(1), 2'd0, cn(4, 0));
        vec(1'b0, 1'b1, 4'd5, 1'b1, 4'd2, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, hn(1'b1, 1'b0), 1'b0, fs(2), 2'd0, cn(5, 1));
        vec(1'b0, 1'b1, 4'd5, 1'b1, 4'd2, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, cn(6, 1));
        nops(3, cn(6, 1));

        // r0 is never a hazard
        vec(1'b0, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, cn(6, 1));
        vec(1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, cn(6, 1));
        vec(1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, cn(6, 1));
        nops(3, cn(6, 1));

        // branch taken while stalled: flush wins, counter frozen, discarded r4 not tracked
        vec(1'b0, 1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, cn(6, 1));
        vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, fs(1), 2'd0, cn(6, 1));
        vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, fs(2), 2'd0, cn(7, 2));
        vec(1'b0, 1'b1, 4'd4, 1'b1, 4'd0, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, cn(7, 2));
        nops(3, cn(7, 2));

        // reset in the second stall cycle, scoreboard empty afterwards
        vec(1'b0, 1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, cn(7, 2));
        vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, fs(1), 2'd0, cn(7, 2));
        vec(1'b1, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, cn(8, 3));
        vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);

        // self-dependent load r3,r3 repeatedly: well over 2^8+5 hold cycles
        for (int i = 0; i < 600; i++) begin
            drv(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);
        end
        nops(1, 8'd255);
        vec(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd255);
        nops(1, 8'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard controller for the 16-bit pipelined core. It tracks in-flight destination registers in a DEPTH-entry scoreboard (EX through WB) and detects RAW hazards for the instruction in ID. It drives PC/IF-ID hold, ID/EX bubble insertion and branch flush, replacing the constant `hold = 0` of the current top level. Optionally it also selects forwarding sources for both ALU operands.

## Interface
- DEPTH, 3 — scoreboard entries after ID; entry 0 = EX, entry DEPTH-1 = WB; legal 2..8
- REG_AW, 4 — register address width
- CNT_W, 16 — stall counter width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high (fixed)
- id_valid  in  1  ID stage holds a real instruction
- id_rs_addr  in  REG_AW  source A register
- id_rs_re  in  1  source A is read
- id_rt_addr  in  REG_AW  source B register
- id_rt_re  in  1  source B is read
- id_rd_addr  in  REG_AW  destination register
- id_rd_we  in  1  instruction writes rd
- id_is_load  in  1  rd is written from data memory
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- hold  out  1  freeze PC and IF/ID
- bubble  out  1  load NOP into ID/EX
- flush  out  1  kill IF/ID and ID/EX contents
- fwd_sel_a  out  $clog2(DEPTH+1)  operand A source: 0 = register file, k = scoreboard entry k-1 (FWD_EN only)
- fwd_sel_b  out  $clog2(DEPTH+1)  same for operand B (FWD_EN only)
- stall_cnt  out  CNT_W  saturating count of hold cycles

## Operation
- Scoreboard entry: {valid, rd, we, load}. On each posedge, entry k+1 <= entry k. Entry 0 <= ID instruction if id_valid && !hold && !flush; otherwise it is loaded invalid.
- A source matches entry k when its re is set, addr != 0 (R0 is hardwired zero), and entry k is valid with we set and rd == addr.
- Register file writes in WB are visible to the ID read in the same cycle, so entry DEPTH-1 never causes a hazard.
- Without FWD_EN: raw_stall = id_valid && any source matching any entry 0..DEPTH-2.
- With FWD_EN: raw_stall = id_valid && a source matching entry 0 with load set (load-use). Otherwise, fwd_sel = 1 + index of the youngest (lowest k) matching entry in 0..DEPTH-2, else 0.
- Flush has priority: flush = ex_branch_taken; hold = raw_stall && !flush; bubble = hold.
- stall_cnt increments on every cycle with hold = 1 and saturates at all-ones.
- Simultaneous branch and stall: flush wins, hold = 0, stall_cnt unchanged, ID instruction discarded.

## Timing
- hold, bubble, flush and fwd_sel are combinational from the registered scoreboard, the ID inputs and ex_branch_taken. Zero-cycle decision.
- Scoreboard and stall_cnt update on posedge clk only.
- Reset: all entries invalid, stall_cnt = 0. During rst, hold, bubble and flush are forced 0 and fwd_sel = 0.
- Reset mid-stall: stall ends the same cycle rst is sampled; the scoreboard is empty next cycle.
- Load-use stall length: without FWD_EN, DEPTH-1 cycles for back-to-back dependence; with FWD_EN, 1 cycle.

## Configuration
- PIPE_FWD_EN defined: forwarding muxes are driven, and only load-use dependences stall.
- PIPE_FWD_EN undefined: fwd_sel_a/b are tied to 0, and every RAW dependence in entries 0..DEPTH-2 stalls until the producer reaches WB.

## Structure
- Shared package: scoreboard entry struct, fwd_sel encoding constants (FWD_RF = 0), and the R0 address constant.
- One sub-module: `pipe_sb_match`, a per-source comparator returning a match vector over the entries and the youngest-match index. It is instantiated twice, once for rs and once for rt.

## Test plan
- Back-to-back ALU dependence (`add r3`, then `add r4,r3,r1`), DEPTH = 3, no FWD -> hold = 1 for 2 cycles, stall_cnt = 2. With FWD -> hold = 0, fwd_sel_a = 1.
- Load r5, then use r5 with FWD -> exactly one hold/bubble cycle, then fwd_sel = 2 (MEM entry).
- Dependence on r0 (`add r0`, then read r0) -> hold never asserts, fwd_sel = 0.
- ex_branch_taken = 1 while ID is stalled on a hazard -> flush = 1, hold = 0, entry 0 invalid next cycle, stall_cnt unchanged.
- rst asserted during the second stall cycle -> outputs 0 that cycle, stall_cnt = 0, scoreboard empty next cycle.
- Force 2^CNT_W + 5 hold cycles -> stall_cnt sticks at all-ones.
